mem_arbiter: RTL

//  Shares one single-port memory (1-port RAM, unified instr+data space) between the core's

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch and data load/store.
// Default build is fixed data priority with a fetch starvation limit; define ARB_RR_EN for round-robin.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rresp,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rresp,
  output logic [31:0] d_rdata,
  // memory port
  output logic        m_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_rresp,
  input  logic [31:0] m_rdata,
  // status / debug
  output logic        proto_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its payload until the cycle its gnt is high;
  // that same cycle the op is strobed to memory (m_ready). Read data returns later with
  // m_rresp and is routed to whichever port owns the single outstanding read.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_I = 2'd1,
    ST_RD_D = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   eligible;
  logic   sel_i;
  logic   sel_d;

  // A new op may issue when nothing is outstanding, or in the cycle the outstanding read returns.
  assign eligible = !reset && ((state_q == ST_IDLE) || m_rresp);

`ifdef ARB_RR_EN
  logic last_i_q;

  always_comb begin : rr_pick
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (eligible) begin
      if (i_req && d_req) begin
        sel_d = last_i_q;
        sel_i = !last_i_q;
      end else begin
        sel_d = d_req;
        sel_i = i_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_i_q <= 1'b1;
    end else if (sel_i || sel_d) begin
      last_i_q <= sel_i;
    end
  end
`else
  logic [CNT_W-1:0] starve_q;
  logic             force_i;

  assign force_i = i_req && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin : fixed_pick
    sel_d = eligible && d_req && !force_i;
    sel_i = eligible && i_req && !sel_d;
  end

  // Counts data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!i_req || sel_i) begin
      starve_q <= '0;
    end else if (sel_d && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    if (sel_i) begin
      state_d = ST_RD_I;
    end else if (sel_d) begin
      state_d = d_we ? ST_IDLE : ST_RD_D;
    end else if (m_rresp) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin : outputs
    i_gnt   = sel_i;
    d_gnt   = sel_d;
    m_ready = sel_i || sel_d;
    m_we    = 1'b0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    m_wstrb = 4'h0;
    if (sel_d) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wstrb = d_we ? d_wstrb : 4'h0;
    end else if (sel_i) begin
      m_addr  = i_addr;
    end

    i_rresp = 1'b0;
    i_rdata = 32'h0;
    d_rresp = 1'b0;
    d_rdata = 32'h0;
    if (m_rresp) begin
      case (state_q)
        ST_RD_I: begin
          i_rresp = 1'b1;
          i_rdata = m_rdata;
        end
        ST_RD_D: begin
          d_rresp = 1'b1;
          d_rdata = m_rdata;
        end
        default: ;
      endcase
    end
  end

  // A response with no read outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (m_rresp && (state_q == ST_IDLE)) begin
      proto_err <= 1'b1;
    end
  end

  assign dbg_state = state_q;

endmodule
